// File: rtl/mdu_ctrl_if.sv
// Bundle of CPU-side request/response and multdiv-side handshake signals for mdu_ctrl.
interface mdu_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    // execute-stage request side
    logic             req_valid;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             kill;
    logic             stall;
    logic [WIDTH-1:0] rdata;

    // architectural state and status
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz_flag;
    logic             busy;

    // multdiv side
    logic             md_start;
    logic             md_multdivb;
    logic             md_signedop;
    logic [WIDTH-1:0] md_x;
    logic [WIDTH-1:0] md_y;
    logic [WIDTH-1:0] md_prodh;
    logic [WIDTH-1:0] md_prodl;
    logic             md_run;
    logic             md_dividebyzero;

    // pipeline plus multdiv view: drives requests and multdiv results
    modport master (
        output req_valid, req_op, req_a, req_b, kill,
        output md_prodh, md_prodl, md_run, md_dividebyzero,
        input  stall, rdata, hi, lo, dz_flag, busy,
        input  md_start, md_multdivb, md_signedop, md_x, md_y
    );

    // controller view
    modport slave (
        input  req_valid, req_op, req_a, req_b, kill,
        input  md_prodh, md_prodl, md_run, md_dividebyzero,
        output stall, rdata, hi, lo, dz_flag, busy,
        output md_start, md_multdivb, md_signedop, md_x, md_y
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Sequencer between the execute stage and the serial multiply/divide unit; owns HI/LO.
module mdu_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    mdu_ctrl_if.slave  bus
);
    localparam int unsigned OP_W = 3;
    localparam logic [OP_W-1:0] OP_MFHI = 3'b100;
    localparam logic [OP_W-1:0] OP_MFLO = 3'b101;
    localparam logic [OP_W-1:0] OP_MTHI = 3'b110;
    localparam logic [OP_W-1:0] OP_MTLO = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_d;
    logic             accept_c;
    logic             launch_c;
    logic             commit_c;
    logic [WIDTH-1:0] rdata_c;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, accept/launch/commit strobes and MFHI/MFLO read mux
    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        launch_c = 1'b0;
        commit_c = 1'b0;
        rdata_c  = '0;
        unique case (state)
            S_IDLE: begin
                accept_c = bus.req_valid;
                if (accept_c) begin
                    if (!bus.req_op[2]) begin
                        launch_c = 1'b1;
                        state_d  = S_START;
                    end else if (bus.req_op == OP_MFHI) begin
                        rdata_c = bus.hi;
                    end else if (bus.req_op == OP_MFLO) begin
                        rdata_c = bus.lo;
                    end
                end
            end
            S_START: begin
                state_d = bus.kill ? S_ABORT : S_WAIT;
            end
            S_WAIT: begin
                if (bus.md_run) begin
                    if (bus.kill) begin
                        state_d = S_ABORT;
                    end
                end else begin
                    // a kill coinciding with completion still drops the result
                    commit_c = ~bus.kill;
                    state_d  = S_IDLE;
                end
            end
            S_ABORT: begin
                if (!bus.md_run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.stall = bus.req_valid & (state != S_IDLE);
    assign bus.busy  = (state != S_IDLE);
    assign bus.rdata = rdata_c;

    // Operand capture, start pulse, HI/LO and divide-by-zero updates
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.hi          <= '0;
            bus.lo          <= '0;
            bus.md_x        <= '0;
            bus.md_y        <= '0;
            bus.md_start    <= 1'b0;
            bus.md_multdivb <= 1'b0;
            bus.md_signedop <= 1'b0;
            bus.dz_flag     <= 1'b0;
        end else begin
            bus.md_start <= launch_c;
            if (launch_c) begin
                bus.md_x        <= bus.req_a;
                bus.md_y        <= bus.req_b;
                bus.md_multdivb <= ~bus.req_op[1];
                bus.md_signedop <= ~bus.req_op[0];
                if (bus.req_op[1]) begin
                    bus.dz_flag <= 1'b0;
                end
            end
            if (accept_c && bus.req_op == OP_MTHI) begin
                bus.hi <= bus.req_a;
            end
            if (accept_c && bus.req_op == OP_MTLO) begin
                bus.lo <= bus.req_a;
            end
            if (commit_c) begin
                bus.hi <= bus.md_prodh;
                bus.lo <= bus.md_prodl;
                if (!bus.md_multdivb) begin
                    bus.dz_flag <= bus.md_dividebyzero;
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with a behavioural multdiv model.
module tb_mdu_ctrl;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = 4;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MFLO  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    int   start_cnt;
    int   run_cnt;

    mdu_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mdu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiply/divide result {high, low}
    function automatic logic [63:0] md_ref(input logic mul, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic        [63:0] up;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (mul) begin
            if (sgn) begin
                sp = 64'(sa) * 64'(sb);
                return sp;
            end
            up = {32'd0, a} * {32'd0, b};
            return up;
        end
        if (b == 32'd0) return 64'd0;
        if (sgn) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    // Serial multdiv stand-in: busy LAT+1 cycles after each start pulse
    always @(posedge clk) begin
        if (!reset) begin
            bus.md_run <= 1'b0;
            run_cnt    <= 0;
        end else if (bus.md_start) begin
            bus.md_run <= 1'b1;
            run_cnt    <= LAT;
            {bus.md_prodh, bus.md_prodl} <= md_ref(bus.md_multdivb, bus.md_signedop,
                                                   bus.md_x, bus.md_y);
            bus.md_dividebyzero <= ~bus.md_multdivb & (bus.md_y == 32'd0);
        end else if (bus.md_run) begin
            if (run_cnt == 0) bus.md_run <= 1'b0;
            else run_cnt <= run_cnt - 1;
        end
    end

    // Count start pulses over the whole run
    always @(posedge clk) begin
        if (bus.md_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present a request, hold it through stalls, return read data and stall count.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rd, output int stalls);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        stalls        = 0;
        #1;
        while (bus.stall && stalls < 200) begin
            @(posedge clk); #1;
            stalls++;
        end
        chk("accept", 32'(bus.stall), 32'd0);
        rd = bus.rdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          st;
        n_vec = 0;
        n_miss = 0;
        start_cnt = 0;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op = 3'b000;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.kill = 1'b0;
        bus.md_prodh = '0;
        bus.md_prodl = '0;
        bus.md_dividebyzero = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.md_start), 32'd0);
        chk("rst_dz", 32'(bus.dz_flag), 32'd0);
        chk("rst_mdx", bus.md_x, 32'd0);
        chk("rst_ctl", {30'd0, bus.md_multdivb, bus.md_signedop}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // MULTU all-ones
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rd, st);
        chk("multu_start", 32'(bus.md_start), 32'd1);
        chk("multu_ctl", {30'd0, bus.md_multdivb, bus.md_signedop}, 32'd2);
        chk("multu_mdx", bus.md_x, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("multu_start_drop", 32'(bus.md_start), 32'd0);
        wait_idle("multu_idle");
        chk("multu_pulses", 32'(start_cnt), 32'd1);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);

        // MULT -1*-1 then MFHI stalled while busy, then MFLO
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rd, st);
        chk("mult_ctl", {30'd0, bus.md_multdivb, bus.md_signedop}, 32'd3);
        issue(OP_MFHI, 32'd0, 32'd0, rd, st);
        chk("mfhi_stalls", 32'(st), 32'(LAT + 3));
        chk("mfhi_rdata", rd, 32'h0000_0000);
        issue(OP_MFLO, 32'd0, 32'd0, rd, st);
        chk("mflo_stalls", 32'(st), 32'd0);
        chk("mflo_rdata", rd, 32'h0000_0001);

        // signed divide, divide by zero, then a clean divide
        issue(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, rd, st);
        chk("div_ctl", {30'd0, bus.md_multdivb, bus.md_signedop}, 32'd1);
        wait_idle("div_idle");
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'h0000_0001);
        chk("div_dz", 32'(bus.dz_flag), 32'd0);
        issue(OP_DIVU, 32'd5, 32'd0, rd, st);
        wait_idle("divu0_idle");
        chk("divu0_dz", 32'(bus.dz_flag), 32'd1);
        issue(OP_DIV, 32'd8, 32'd2, rd, st);
        chk("div82_dz_clr", 32'(bus.dz_flag), 32'd0);
        wait_idle("div82_idle");
        chk("div82_dz", 32'(bus.dz_flag), 32'd0);
        chk("div82_lo", bus.lo, 32'd4);
        chk("div82_hi", bus.hi, 32'd0);

        // MTHI/MTLO, then a killed MULT leaves HI/LO untouched
        issue(OP_MTHI, 32'h1234_5678, 32'd0, rd, st);
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0, rd, st);
        chk("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
        issue(OP_MFHI, 32'd0, 32'd0, rd, st);
        chk("mthi_readback", rd, 32'h1234_5678);
        issue(OP_MULT, 32'd3, 32'd5, rd, st);
        @(posedge clk); #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        chk("kill_busy", 32'(bus.busy), 32'd1);
        wait_idle("kill_idle");
        chk("kill_run_low", 32'(bus.md_run), 32'd0);
        chk("kill_hi", bus.hi, 32'h1234_5678);
        chk("kill_lo", bus.lo, 32'h9ABC_DEF0);

        // reset in the middle of a DIVU
        issue(OP_DIVU, 32'd100, 32'd7, rd, st);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op = OP_MFHI;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        chk("mid_rst_hi", bus.hi, 32'd0);
        chk("mid_rst_lo", bus.lo, 32'd0);
        chk("mid_rst_start", 32'(bus.md_start), 32'd0);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(OP_MULTU, 32'd3, 32'd4, rd, st);
        wait_idle("post_rst_idle");
        chk("post_rst_hi", bus.hi, 32'd0);
        chk("post_rst_lo", bus.lo, 32'h0000_000C);

        // back-to-back: second op accepted on the first IDLE cycle
        issue(OP_MULTU, 32'd2, 32'd3, rd, st);
        issue(OP_DIVU, 32'h2345_6789, 32'hABCD_EF01, rd, st);
        chk("b2b_stalls", 32'(st), 32'(LAT + 3));
        chk("b2b_first_lo", bus.lo, 32'd6);
        chk("b2b_mdx", bus.md_x, 32'h2345_6789);
        chk("b2b_ctl", {30'd0, bus.md_multdivb, bus.md_signedop}, 32'd0);
        wait_idle("b2b_idle");
        chk("b2b_hi", bus.hi, 32'h2345_6789);
        chk("b2b_lo", bus.lo, 32'h0000_0000);
        chk("total_pulses", 32'(start_cnt), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
